// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory bus: CPU-side master drives request strobes, memory-side slave
// returns read data plus completion/error pulses.
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word-organised RAM responder for the LC-3b memory interface.
// A request is latched in IDLE, counted down in BUSY, and completed with a
// single-cycle mem_resp in RESP. The RAM write and read-data capture both
// happen on the edge that enters RESP.
module lc3b_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lc3b_mem_responder_if.slave    bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [14:0]   word_q;
  logic [15:0]   wdata_q;
  logic [1:0]    be_q;

  logic [15:0]   ram [DEPTH_WORDS];

  logic          one_req, both_req;
  logic          cur_wr;
  logic [14:0]   cur_word;
  logic [15:0]   cur_wdata;
  logic [1:0]    cur_be;
  logic          in_range;
  logic [AW-1:0] ram_idx;
  logic          go_resp;
  logic          commit_wr;
  logic          unused_addr0;

  assign unused_addr0 = bus.mem_address[0];

  // In IDLE the live bus is the operand source (needed when LATENCY==1 jumps
  // straight to RESP); otherwise the latched request is used.
  always_comb begin
    one_req   = bus.mem_read ^ bus.mem_write;
    both_req  = bus.mem_read & bus.mem_write;
    cur_wr    = op_wr;
    cur_word  = word_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == IDLE) begin
      cur_wr    = bus.mem_write;
      cur_word  = bus.mem_address[15:1];
      cur_wdata = bus.mem_wdata;
      cur_be    = bus.mem_byte_enable;
    end
    in_range  = ({1'b0, cur_word} < DEPTH16);
    ram_idx   = cur_word[AW-1:0];
    go_resp   = ((state == IDLE) && one_req && (LATENCY == 1)) ||
                ((state == BUSY) && (cnt == CW'(1)));
    commit_wr = rst_n && go_resp && cur_wr && in_range;
  end

  // Request FSM with registered resp/err/rdata outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      op_wr         <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      bus.mem_resp  <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.mem_rdata <= 16'h0000;
    end else begin
      bus.mem_resp <= 1'b0;
      bus.mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (both_req) begin
            // Conflicting strobes: flag and keep re-sampling.
            bus.mem_err <= 1'b1;
          end else if (one_req) begin
            op_wr   <= bus.mem_write;
            word_q  <= bus.mem_address[15:1];
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_byte_enable;
            cnt     <= CW'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY:    if (cnt != CW'(1)) cnt <= cnt - CW'(1);
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Entering RESP overrides the case above (covers LATENCY==1 from IDLE).
      if (go_resp) begin
        state        <= RESP;
        bus.mem_resp <= 1'b1;
        bus.mem_err  <= !in_range;
        if (!cur_wr) bus.mem_rdata <= in_range ? ram[ram_idx] : 16'h0000;
      end
    end
  end

  // RAM write on enabled byte lanes; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      if (cur_be[1]) ram[ram_idx][15:8] <= cur_wdata[15:8];
      if (cur_be[0]) ram[ram_idx][7:0]  <= cur_wdata[7:0];
    end
  end
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses (with expected cycle),
// per-DUT monitors pop and compare on every mem_resp/mem_err pulse.
module tb_lc3b_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  typedef struct {
    logic        resp;
    logic        err;
    logic        chk;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  lc3b_mem_responder_if a ();
  lc3b_mem_responder_if b ();

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(a.slave));
  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Monitor for the LATENCY=3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (a.mem_resp || a.mem_err) begin
      if (q0.size() == 0) begin
        total++;
        $display("FAIL d0_unexpected: resp=%0b err=%0b at cyc %0d, expected nothing",
                 a.mem_resp, a.mem_err, cyc);
      end else begin
        e = q0.pop_front();
        chk("d0_resp", 32'(a.mem_resp), 32'(e.resp));
        chk("d0_err", 32'(a.mem_err), 32'(e.err));
        chk("d0_cycle", cyc, e.cyc);
        if (e.chk) chk("d0_rdata", 32'(a.mem_rdata), 32'(e.rdata));
      end
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (b.mem_resp || b.mem_err) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL d1_unexpected: resp=%0b err=%0b at cyc %0d, expected nothing",
                 b.mem_resp, b.mem_err, cyc);
      end else begin
        e = q1.pop_front();
        chk("d1_resp", 32'(b.mem_resp), 32'(e.resp));
        chk("d1_err", 32'(b.mem_err), 32'(e.err));
        chk("d1_cycle", cyc, e.cyc);
        if (e.chk) chk("d1_rdata", 32'(b.mem_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic drive(input int d, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
    if (d == 0) begin
      a.mem_read = rd; a.mem_write = wr; a.mem_address = addr;
      a.mem_wdata = wdata; a.mem_byte_enable = be;
    end else begin
      b.mem_read = rd; b.mem_write = wr; b.mem_address = addr;
      b.mem_wdata = wdata; b.mem_byte_enable = be;
    end
  endtask

  // Issue one request, hold it until mem_resp, then release it.
  task automatic do_req(input int d, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input logic err, input logic [15:0] rdata);
    exp_t e;
    logic seen;
    int   lat;
    lat = (d == 0) ? 3 : 1;
    e.resp = 1'b1; e.err = err; e.chk = !wr; e.rdata = rdata; e.cyc = cyc + lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive(d, !wr, wr, addr, wdata, be);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (d == 0) ? a.mem_resp : b.mem_resp;
    end
    if (!seen) begin
      total++;
      $display("FAIL d%0d_timeout: no mem_resp for addr %0h, expected one", d, addr);
    end
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rdata0"}, 32'(a.mem_rdata), 32'h0);
    chk({tag, "_resp0"}, 32'(a.mem_resp), 32'h0);
    chk({tag, "_err0"}, 32'(a.mem_err), 32'h0);
    chk({tag, "_rdata1"}, 32'(b.mem_rdata), 32'h0);
  endtask

  initial begin
    exp_t e;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write, read back; byte lanes; empty byte enable.
    do_req(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, 16'h0);
    do_req(0, 1'b0, 16'h0010, 16'h0, 2'b00, 1'b0, 16'hBEEF);
    do_req(0, 1'b1, 16'h0010, 16'h1234, 2'b10, 1'b0, 16'h0);
    do_req(0, 1'b0, 16'h0010, 16'h0, 2'b00, 1'b0, 16'h12EF);
    do_req(0, 1'b1, 16'h0011, 16'hFFFF, 2'b00, 1'b0, 16'h0);
    do_req(0, 1'b0, 16'h0011, 16'h0, 2'b00, 1'b0, 16'h12EF);

    // Out of range: word 256 must not alias word 0.
    do_req(0, 1'b1, 16'h0000, 16'h0F0F, 2'b11, 1'b0, 16'h0);
    do_req(0, 1'b1, 16'h0200, 16'hDEAD, 2'b11, 1'b1, 16'h0);
    do_req(0, 1'b0, 16'h0200, 16'h0, 2'b00, 1'b1, 16'h0000);
    do_req(0, 1'b0, 16'h0000, 16'h0, 2'b00, 1'b0, 16'h0F0F);

    // Both strobes for two cycles: two error pulses, no response.
    for (int i = 1; i <= 2; i++) begin
      e.resp = 1'b0; e.err = 1'b1; e.chk = 1'b0; e.rdata = 16'h0; e.cyc = cyc + i;
      q0.push_back(e);
    end
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h0, 2'b11);
    @(posedge clk); @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    do_req(0, 1'b0, 16'h0010, 16'h0, 2'b00, 1'b0, 16'h12EF);

    // Back-to-back reads; cycle check enforces LATENCY+1 spacing.
    do_req(0, 1'b1, 16'h0002, 16'h2222, 2'b11, 1'b0, 16'h0);
    do_req(0, 1'b1, 16'h0004, 16'h4444, 2'b11, 1'b0, 16'h0);
    do_req(0, 1'b1, 16'h0006, 16'h5555, 2'b11, 1'b0, 16'h0);
    do_req(0, 1'b0, 16'h0002, 16'h0, 2'b00, 1'b0, 16'h2222);
    do_req(0, 1'b0, 16'h0004, 16'h0, 2'b00, 1'b0, 16'h4444);

    // Reset during BUSY of a write: no response, no commit, outputs cleared.
    drive(0, 1'b0, 1'b1, 16'h0006, 16'hAAAA, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0006, 16'h0, 2'b00, 1'b0, 16'h5555);

    // LATENCY=1 instance.
    do_req(1, 1'b1, 16'h0008, 16'h1357, 2'b11, 1'b0, 16'h0);
    do_req(1, 1'b0, 16'h0008, 16'h0, 2'b00, 1'b0, 16'h1357);
    do_req(1, 1'b1, 16'h0300, 16'h9999, 2'b01, 1'b1, 16'h0);
    do_req(1, 1'b0, 16'h0300, 16'h0, 2'b00, 1'b1, 16'h0000);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("d0_queue_drained", 32'(q0.size()), 32'h0);
    chk("d1_queue_drained", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1);
  end
endmodule
